dm_sba_multibeat: RTL and testbench
===================================

// Module: dm_sba_multibeat
// PURPOSE
//   System Bus Access master for the debug module, generalised in address width, bus width and access size.
//   Accesses wider than the bus are split into sequential beats. Adds alignment and bus-error checking,
//   busy-error detection and an optional response timeout.
//   Sits between dm_csrs (sbcs/sbaddress/sbdata) and the SoC bus master port.
// PARAMETERS
//   AddrWidth      32   address width of sbaddress and the master port
//   BusWidth       32   master data width: 32 or 64
//   MaxAccessBits  128  widest supported sbaccess: 32..128, and >= BusWidth
//   ReadByteEnable 1    1: drive byte enables on reads; 0: master_be_o='0 on reads
//   TimeoutCycles  1023 response timeout; used only with DM_SBA_TIMEOUT_EN
// PORTS
//   clk_i             in  1              clock
//   rst_i             in  1              async reset, active-high
//   dmactive_i        in  1              0: synchronous abort to Idle
//   sbaddress_i       in  AddrWidth      current sbaddress
//   sbaddress_write_valid_i in 1         debugger wrote sbaddress
//   sbreadonaddr_i    in  1              read on sbaddress write
//   sbreadondata_i    in  1              read on sbdata read
//   sbautoincrement_i in  1              increment address after success
//   sbaccess_i        in  3              log2(access bytes)
//   sbdata_i          in  MaxAccessBits  write data
//   sbdata_read_valid_i  in 1            debugger read sbdata0
//   sbdata_write_valid_i in 1            debugger wrote sbdata0
//   sbaddress_o       out AddrWidth      next sbaddress
//   sbdata_o          out MaxAccessBits  assembled read data
//   sbdata_valid_o    out 1              1-cycle pulse: read complete
//   sbbusy_o          out 1              state != Idle
//   sbbusyerror_o     out 1              1-cycle pulse: trigger while busy
//   sberror_valid_o   out 1              1-cycle pulse with sberror_o
//   sberror_o         out 3              1 timeout, 2 bus error, 3 misaligned, 4 bad size
//   master_req_o / master_add_o[AddrWidth] / master_we_o / master_wdata_o[BusWidth] / master_be_o[BusWidth/8]  out
//   master_gnt_i / master_r_valid_i / master_r_err_i / master_r_rdata_i[BusWidth]  in
// BEHAVIOUR
//   Reset: state Idle, beat count 0, sbdata_o '0; all pulse outputs and master_req_o 0; sbaddress_o=sbaddress_i.
//   States: Idle -> Req -> Wait -> (Req for next beat | Idle). Exactly one transaction outstanding.
//   Idle trigger priority: sbdata_write_valid_i > (sbdata_read_valid_i & sbreadondata_i)
//     > (sbaddress_write_valid_i & sbreadonaddr_i). Triggers latch sbaccess/address/data.
//   Checks at trigger, before any request: (8<<sbaccess)>MaxAccessBits -> err 4;
//     address not aligned to access size -> err 3; either: no request, stay Idle, error pulse next cycle.
//   Beats N = max(1, (1<<sbaccess)/(BusWidth/8)); beat k address = base + k*BusWidth/8.
//   Req: master_req_o=1, hold add/we/wdata/be until master_gnt_i; gnt -> Wait.
//   Wait: on master_r_valid_i (reads and writes): err -> error 2, Idle, remaining beats dropped, no increment;
//     else last beat -> Idle, else Req (next beat, no idle cycle required).
//   Sub-bus accesses: be = size mask at address byte offset; wdata lanes shifted to offset;
//     rdata shifted down by offset, zero-extended into sbdata_o.
//   Wide reads: beat k -> sbdata_o[k*BusWidth +: BusWidth]; sbdata_valid_o pulses on last-beat response.
//   Autoincrement: on success only, sbaddress_o = base + (1<<sbaccess) for exactly the completion cycle,
//     modulo 2^AddrWidth (wraps silently).
//   Any trigger while busy: ignored, sbbusyerror_o pulses once per trigger.
//   dmactive_i=0: next edge Idle, beat count 0, no pulses; late responses in Idle are dropped.
//   Async reset mid-access: immediate Idle; master_req_o drops without waiting for gnt.
// CONFIGURATION
//   DM_SBA_TIMEOUT_EN defined: counter cleared on entering Req/Wait, increments each cycle there;
//     reaching TimeoutCycles -> error 1, Idle, abort. Undefined: no counter; waits forever; code 1 never occurs.
// STRUCTURE
//   Package dm: sba_state_e {Idle, Req, Wait}; error codes SbErrTimeout=1, SbErrBus=2, SbErrAlign=3, SbErrSize=4.
//   Sub-module dm_sba_be_gen: combinational be/lane-shift from sbaccess + offset.
// TESTING
//   BusWidth=32, sbaccess=0, addr 0x1003, readonaddr -> be=4'b1000, rdata 0xAB000000 -> sbdata_o=0xAB.
//   BusWidth=32, sbaccess=4, addr 0x2000, write -> 4 beats 0x2000..0x200C, wdata = sbdata_i words in order.
//   sbaccess=2, addr 0x3002 -> no master_req_o, sberror_o=3; sbaccess=5 -> sberror_o=4.
//   128-bit read, beat 2 r_err -> sberror_o=2, beat 3 not issued, autoincrement addr unchanged.
//   sbdata write while busy -> sbbusyerror_o 1 cycle, request stream unchanged; dmactive_i=0 in Wait -> Idle.
//   TIMEOUT_EN, TimeoutCycles=16, gnt never asserted -> sberror_o=1 after 16 cycles, sbbusy_o=0.

Source files
------------

// File: rtl/dm_sba_multibeat_pkg.sv
// Shared types and error codes for the debug-module system bus access master.
package dm_sba_multibeat_pkg;

  typedef enum logic [1:0] {
    Idle = 2'd0,
    Req  = 2'd1,
    Wait = 2'd2
  } sba_state_e;

  localparam logic [2:0] SbErrTimeout = 3'd1;
  localparam logic [2:0] SbErrBus     = 3'd2;
  localparam logic [2:0] SbErrAlign   = 3'd3;
  localparam logic [2:0] SbErrSize    = 3'd4;

  function automatic logic [31:0] access_bytes(input logic [2:0] sbaccess);
    return 32'd1 << sbaccess;
  endfunction

endpackage

// File: rtl/dm_sba_be_gen.sv
// Byte-enable and lane steering for one bus beat; sub-bus accesses sit at the
// address byte offset, accesses of bus width or wider use the full lane set.
module dm_sba_be_gen
  import dm_sba_multibeat_pkg::*;
#(
  parameter int BusWidth = 32
) (
  input  logic [2:0]                      sbaccess_i,
  input  logic [$clog2(BusWidth/8)-1:0]   offset_i,
  input  logic [BusWidth-1:0]             wdata_i,
  input  logic [BusWidth-1:0]             rdata_i,
  output logic [BusWidth/8-1:0]           be_o,
  output logic [BusWidth-1:0]             wdata_o,
  output logic [BusWidth-1:0]             rdata_o
);

  localparam int BusBytes = BusWidth / 8;

  int                  nbytes;
  logic [BusWidth-1:0] size_mask;

  always_comb begin
    nbytes    = int'(access_bytes(sbaccess_i));
    be_o      = '0;
    size_mask = '0;
    for (int i = 0; i < BusBytes; i++) begin
      if (nbytes >= BusBytes ||
          (i >= int'(offset_i) && i < int'(offset_i) + nbytes)) begin
        be_o[i] = 1'b1;
      end
      if (nbytes >= BusBytes || i < nbytes) begin
        size_mask[i*8 +: 8] = 8'hff;
      end
    end
    wdata_o = wdata_i << {offset_i, 3'b000};
    // read data is returned right-justified and zero-extended to the access size
    rdata_o = (rdata_i >> {offset_i, 3'b000}) & size_mask;
  end

endmodule

// File: rtl/dm_sba_multibeat.sv
// System bus access master: splits wide sbaccess sizes into bus beats, checks
// size/alignment/bus errors. Optional response timeout: define DM_SBA_TIMEOUT_EN.
module dm_sba_multibeat
  import dm_sba_multibeat_pkg::*;
#(
  parameter int AddrWidth      = 32,
  parameter int BusWidth       = 32,
  parameter int MaxAccessBits  = 128,
  parameter int ReadByteEnable = 1,
  parameter int TimeoutCycles  = 1023
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     dmactive_i,
  input  logic [AddrWidth-1:0]     sbaddress_i,
  input  logic                     sbaddress_write_valid_i,
  input  logic                     sbreadonaddr_i,
  input  logic                     sbreadondata_i,
  input  logic                     sbautoincrement_i,
  input  logic [2:0]               sbaccess_i,
  input  logic [MaxAccessBits-1:0] sbdata_i,
  input  logic                     sbdata_read_valid_i,
  input  logic                     sbdata_write_valid_i,
  output logic [AddrWidth-1:0]     sbaddress_o,
  output logic [MaxAccessBits-1:0] sbdata_o,
  output logic                     sbdata_valid_o,
  output logic                     sbbusy_o,
  output logic                     sbbusyerror_o,
  output logic                     sberror_valid_o,
  output logic [2:0]               sberror_o,
  output logic                     master_req_o,
  output logic [AddrWidth-1:0]     master_add_o,
  output logic                     master_we_o,
  output logic [BusWidth-1:0]      master_wdata_o,
  output logic [BusWidth/8-1:0]    master_be_o,
  input  logic                     master_gnt_i,
  input  logic                     master_r_valid_i,
  input  logic                     master_r_err_i,
  input  logic [BusWidth-1:0]      master_r_rdata_i
);

  localparam int BusBytes = BusWidth / 8;
  localparam int BbLog    = $clog2(BusBytes);
  localparam int MaxBeats = MaxAccessBits / BusWidth;
  localparam int BeatW    = 8;

  sba_state_e               state_q, state_d;
  logic [BeatW-1:0]         beat_q, beat_d;
  logic [2:0]               access_q;
  logic [AddrWidth-1:0]     base_q, next_addr_q;
  logic [MaxAccessBits-1:0] wdata_q, rdata_q;
  logic                     we_q;
  logic                     busyerr_q, err_valid_q, rd_done_q, inc_q;
  logic [2:0]               err_q;

  logic trig_wr, any_trig, size_bad, misaligned, timeout, last_beat;
  logic latch, busyerr_d, err_valid_d, complete, rsp_ok;
  logic [2:0]           err_code_d;
  logic [BeatW-1:0]     n_beats;
  logic [31:0]          nbytes;
  logic [AddrWidth-1:0] beat_addr;
  logic [BusWidth-1:0]  beat_wdata, lane_wdata, lane_rdata;
  logic [BusBytes-1:0]  lane_be;

  assign trig_wr  = sbdata_write_valid_i;
  assign any_trig = trig_wr | (sbdata_read_valid_i & sbreadondata_i)
                  | (sbaddress_write_valid_i & sbreadonaddr_i);

  assign size_bad   = (32'd8 << sbaccess_i) > 32'(MaxAccessBits);
  assign misaligned = |(sbaddress_i & ~({AddrWidth{1'b1}} << sbaccess_i));

  assign nbytes    = access_bytes(access_q);
  assign n_beats   = (nbytes > 32'(BusBytes)) ? BeatW'(nbytes >> BbLog) : BeatW'(1);
  assign last_beat = (beat_q == n_beats - BeatW'(1));
  assign beat_addr = base_q + (AddrWidth'(beat_q) << BbLog);

  always_comb begin
    beat_wdata = '0;
    for (int k = 0; k < MaxBeats; k++) begin
      if (beat_q == BeatW'(k)) beat_wdata = wdata_q[k*BusWidth +: BusWidth];
    end
  end

  dm_sba_be_gen #(.BusWidth(BusWidth)) u_be_gen (
    .sbaccess_i (access_q),
    .offset_i   (beat_addr[BbLog-1:0]),
    .wdata_i    (beat_wdata),
    .rdata_i    (master_r_rdata_i),
    .be_o       (lane_be),
    .wdata_o    (lane_wdata),
    .rdata_o    (lane_rdata)
  );

`ifdef DM_SBA_TIMEOUT_EN
  localparam int TmoW = $clog2(TimeoutCycles + 1);
  logic [TmoW-1:0] tmo_q;

  assign timeout = (state_q != Idle) && (tmo_q == TmoW'(TimeoutCycles - 1));

  // restarts on every Req/Wait entry, including Wait -> Req for the next beat
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                     tmo_q <= '0;
    else if (state_d != state_q)   tmo_q <= '0;
    else if (state_q != Idle)      tmo_q <= tmo_q + TmoW'(1);
  end
`else
  // counter compiled out: a response is waited for indefinitely
  assign timeout = (TimeoutCycles < 0);
`endif

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    latch       = 1'b0;
    busyerr_d   = 1'b0;
    err_valid_d = 1'b0;
    err_code_d  = err_q;
    complete    = 1'b0;
    rsp_ok      = 1'b0;
    case (state_q)
      Idle: begin
        if (any_trig) begin
          if (size_bad) begin
            err_valid_d = 1'b1;
            err_code_d  = SbErrSize;
          end else if (misaligned) begin
            err_valid_d = 1'b1;
            err_code_d  = SbErrAlign;
          end else begin
            latch   = 1'b1;
            state_d = Req;
            beat_d  = '0;
          end
        end
      end
      Req: if (master_gnt_i) state_d = Wait;
      Wait: begin
        if (master_r_valid_i) begin
          if (master_r_err_i) begin
            err_valid_d = 1'b1;
            err_code_d  = SbErrBus;
            state_d     = Idle;
            beat_d      = '0;
          end else begin
            rsp_ok = 1'b1;
            if (last_beat) begin
              complete = 1'b1;
              state_d  = Idle;
              beat_d   = '0;
            end else begin
              state_d = Req;
              beat_d  = beat_q + BeatW'(1);
            end
          end
        end
      end
      default: state_d = Idle;
    endcase
    if (state_q != Idle && any_trig) busyerr_d = 1'b1;
    if (timeout) begin
      state_d     = Idle;
      beat_d      = '0;
      err_valid_d = 1'b1;
      err_code_d  = SbErrTimeout;
      complete    = 1'b0;
      rsp_ok      = 1'b0;
    end
    if (!dmactive_i) begin
      state_d     = Idle;
      beat_d      = '0;
      latch       = 1'b0;
      busyerr_d   = 1'b0;
      err_valid_d = 1'b0;
      err_code_d  = err_q;
      complete    = 1'b0;
      rsp_ok      = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= Idle;
      beat_q      <= '0;
      busyerr_q   <= 1'b0;
      err_valid_q <= 1'b0;
      err_q       <= '0;
      rd_done_q   <= 1'b0;
      inc_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      busyerr_q   <= busyerr_d;
      err_valid_q <= err_valid_d;
      err_q       <= err_code_d;
      rd_done_q   <= complete & ~we_q;
      inc_q       <= complete & sbautoincrement_i;
      if (rsp_ok && !we_q) begin
        if (beat_q == '0) rdata_q <= MaxAccessBits'(lane_rdata);
        for (int k = 1; k < MaxBeats; k++) begin
          if (beat_q == BeatW'(k)) rdata_q[k*BusWidth +: BusWidth] <= lane_rdata;
        end
      end
    end
  end

  // transaction payload: captured at trigger, no reset needed
  always_ff @(posedge clk_i) begin
    if (latch) begin
      access_q <= sbaccess_i;
      base_q   <= sbaddress_i;
      wdata_q  <= sbdata_i;
      we_q     <= trig_wr;
    end
    if (complete) next_addr_q <= base_q + AddrWidth'(nbytes);
  end

  assign sbaddress_o     = inc_q ? next_addr_q : sbaddress_i;
  assign sbdata_o        = rdata_q;
  assign sbdata_valid_o  = rd_done_q;
  assign sbbusy_o        = (state_q != Idle);
  assign sbbusyerror_o   = busyerr_q;
  assign sberror_valid_o = err_valid_q;
  assign sberror_o       = err_q;

  assign master_req_o   = (state_q == Req);
  assign master_add_o   = beat_addr;
  assign master_we_o    = we_q;
  assign master_wdata_o = lane_wdata;
  assign master_be_o    = (we_q || ReadByteEnable != 0) ? lane_be : '0;

endmodule

// File: tb/tb_dm_sba_multibeat.sv
// Directed bench for dm_sba_multibeat (BusWidth 32, MaxAccessBits 128).
module tb_dm_sba_multibeat;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         dmactive_i;
  logic [31:0]  sbaddress_i;
  logic         sbaddress_write_valid_i, sbreadonaddr_i, sbreadondata_i, sbautoincrement_i;
  logic [2:0]   sbaccess_i;
  logic [127:0] sbdata_i;
  logic         sbdata_read_valid_i, sbdata_write_valid_i;
  logic [31:0]  sbaddress_o;
  logic [127:0] sbdata_o;
  logic         sbdata_valid_o, sbbusy_o, sbbusyerror_o, sberror_valid_o;
  logic [2:0]   sberror_o;
  logic         master_req_o, master_we_o;
  logic [31:0]  master_add_o, master_wdata_o;
  logic [3:0]   master_be_o;
  logic         master_gnt_i, master_r_valid_i, master_r_err_i;
  logic [31:0]  master_r_rdata_i;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk_i = ~clk_i;

  dm_sba_multibeat #(
    .AddrWidth(32), .BusWidth(32), .MaxAccessBits(128),
    .ReadByteEnable(1), .TimeoutCycles(16)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .dmactive_i(dmactive_i),
    .sbaddress_i(sbaddress_i), .sbaddress_write_valid_i(sbaddress_write_valid_i),
    .sbreadonaddr_i(sbreadonaddr_i), .sbreadondata_i(sbreadondata_i),
    .sbautoincrement_i(sbautoincrement_i), .sbaccess_i(sbaccess_i),
    .sbdata_i(sbdata_i), .sbdata_read_valid_i(sbdata_read_valid_i),
    .sbdata_write_valid_i(sbdata_write_valid_i),
    .sbaddress_o(sbaddress_o), .sbdata_o(sbdata_o), .sbdata_valid_o(sbdata_valid_o),
    .sbbusy_o(sbbusy_o), .sbbusyerror_o(sbbusyerror_o),
    .sberror_valid_o(sberror_valid_o), .sberror_o(sberror_o),
    .master_req_o(master_req_o), .master_add_o(master_add_o), .master_we_o(master_we_o),
    .master_wdata_o(master_wdata_o), .master_be_o(master_be_o),
    .master_gnt_i(master_gnt_i), .master_r_valid_i(master_r_valid_i),
    .master_r_err_i(master_r_err_i), .master_r_rdata_i(master_r_rdata_i)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // one beat from Req: check the request, grant it, then respond
  task automatic do_beat(input string tag, input logic [31:0] addr, input logic we,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input logic [31:0] rdata, input logic err);
    chk({tag, "_req"}, master_req_o, 1'b1);
    chk({tag, "_add"}, master_add_o, addr);
    chk({tag, "_we"}, master_we_o, we);
    if (we) chk({tag, "_wdata"}, master_wdata_o, wdata);
    chk({tag, "_be"}, master_be_o, be);
    master_gnt_i = 1'b1;
    tick();
    master_gnt_i = 1'b0;
    chk({tag, "_wait_noreq"}, master_req_o, 1'b0);
    master_r_valid_i = 1'b1;
    master_r_rdata_i = rdata;
    master_r_err_i   = err;
    tick();
    master_r_valid_i = 1'b0;
    master_r_err_i   = 1'b0;
  endtask

  task automatic trig_addr(input logic [2:0] acc, input logic [31:0] addr);
    sbaccess_i = acc;
    sbaddress_i = addr;
    sbreadonaddr_i = 1'b1;
    sbaddress_write_valid_i = 1'b1;
    tick();
    sbaddress_write_valid_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    int errs;
    rst_i = 1'b1; dmactive_i = 1'b1; sbaddress_i = 32'h55;
    sbaddress_write_valid_i = 0; sbreadonaddr_i = 0; sbreadondata_i = 0;
    sbautoincrement_i = 0; sbaccess_i = 3'd2; sbdata_i = '0;
    sbdata_read_valid_i = 0; sbdata_write_valid_i = 0;
    master_gnt_i = 0; master_r_valid_i = 0; master_r_err_i = 0; master_r_rdata_i = '0;
    tick(); tick();
    chk("rst_busy", sbbusy_o, 1'b0);
    chk("rst_req", master_req_o, 1'b0);
    chk("rst_sbdata", sbdata_o, 128'h0);
    chk("rst_pulses", {sbdata_valid_o, sbbusyerror_o, sberror_valid_o}, 3'b000);
    chk("rst_addr", sbaddress_o, 32'h55);
    rst_i = 1'b0;
    tick();

    // byte read at offset 3
    trig_addr(3'd0, 32'h1003);
    sbreadonaddr_i = 1'b0;
    do_beat("b0", 32'h1003, 1'b0, 32'h0, 4'b1000, 32'hAB000000, 1'b0);
    chk("b0_valid", sbdata_valid_o, 1'b1);
    chk("b0_data", sbdata_o, 128'hAB);
    chk("b0_busy", sbbusy_o, 1'b0);
    chk("b0_addr", sbaddress_o, 32'h1003);
    tick();
    chk("b0_valid_drop", sbdata_valid_o, 1'b0);

    // 128-bit write, with a busy trigger inserted in beat 1
    sbaccess_i = 3'd4; sbaddress_i = 32'h2000; sbautoincrement_i = 1'b1;
    sbdata_i = 128'hDDDD0003_CCCC0002_BBBB0001_AAAA0000;
    sbdata_write_valid_i = 1'b1;
    tick();
    sbdata_write_valid_i = 1'b0;
    do_beat("w0", 32'h2000, 1'b1, 32'hAAAA0000, 4'hF, 32'h0, 1'b0);
    sbdata_write_valid_i = 1'b1; sbdata_i = {4{32'hDEADBEEF}};
    tick();
    sbdata_write_valid_i = 1'b0;
    chk("busyerr_pulse", sbbusyerror_o, 1'b1);
    chk("busyerr_add", master_add_o, 32'h2004);
    chk("busyerr_wdata", master_wdata_o, 32'hBBBB0001);
    tick();
    chk("busyerr_once", sbbusyerror_o, 1'b0);
    do_beat("w1", 32'h2004, 1'b1, 32'hBBBB0001, 4'hF, 32'h0, 1'b0);
    do_beat("w2", 32'h2008, 1'b1, 32'hCCCC0002, 4'hF, 32'h0, 1'b0);
    do_beat("w3", 32'h200C, 1'b1, 32'hDDDD0003, 4'hF, 32'h0, 1'b0);
    chk("w_autoinc", sbaddress_o, 32'h2010);
    chk("w_noval", sbdata_valid_o, 1'b0);
    chk("w_noerr", sberror_valid_o, 1'b0);
    chk("w_idle", sbbusy_o, 1'b0);
    tick();
    chk("w_autoinc_1cyc", sbaddress_o, 32'h2000);

    // misaligned word, then oversize access
    trig_addr(3'd2, 32'h3002);
    chk("align_req", master_req_o, 1'b0);
    chk("align_busy", sbbusy_o, 1'b0);
    chk("align_err", {sberror_valid_o, sberror_o}, {1'b1, 3'd3});
    tick();
    chk("align_err_drop", sberror_valid_o, 1'b0);
    trig_addr(3'd5, 32'h4000);
    chk("size_req", master_req_o, 1'b0);
    chk("size_err", {sberror_valid_o, sberror_o}, {1'b1, 3'd4});
    tick();

    // 128-bit read, bus error on beat 2
    trig_addr(3'd4, 32'h5000);
    sbreadonaddr_i = 1'b0;
    do_beat("r0", 32'h5000, 1'b0, 32'h0, 4'hF, 32'h1, 1'b0);
    do_beat("r1", 32'h5004, 1'b0, 32'h0, 4'hF, 32'h2, 1'b0);
    do_beat("r2", 32'h5008, 1'b0, 32'h0, 4'hF, 32'h3, 1'b1);
    chk("rerr_err", {sberror_valid_o, sberror_o}, {1'b1, 3'd2});
    chk("rerr_noval", sbdata_valid_o, 1'b0);
    chk("rerr_noinc", sbaddress_o, 32'h5000);
    chk("rerr_busy", sbbusy_o, 1'b0);
    tick();
    chk("rerr_no_beat3", master_req_o, 1'b0);

    // 64-bit read triggered by sbdata read
    sbaccess_i = 3'd3; sbaddress_i = 32'h6000; sbreadondata_i = 1'b1;
    sbdata_read_valid_i = 1'b1;
    tick();
    sbdata_read_valid_i = 1'b0; sbreadondata_i = 1'b0;
    do_beat("d0", 32'h6000, 1'b0, 32'h0, 4'hF, 32'h11111111, 1'b0);
    do_beat("d1", 32'h6004, 1'b0, 32'h0, 4'hF, 32'h22222222, 1'b0);
    chk("d_data", sbdata_o, 128'h22222222_11111111);
    chk("d_valid", sbdata_valid_o, 1'b1);
    chk("d_autoinc", sbaddress_o, 32'h6008);
    tick();

    // halfword write at offset 2, no autoincrement
    sbautoincrement_i = 1'b0;
    sbaccess_i = 3'd1; sbaddress_i = 32'h7002; sbdata_i = 128'hBEEF;
    sbdata_write_valid_i = 1'b1;
    tick();
    sbdata_write_valid_i = 1'b0;
    do_beat("h0", 32'h7002, 1'b1, 32'hBEEF0000, 4'b1100, 32'h0, 1'b0);
    chk("h_noinc", sbaddress_o, 32'h7002);
    tick();

    // dmactive drop while waiting for the response
    trig_addr(3'd2, 32'h8000);
    sbreadonaddr_i = 1'b0;
    chk("dm_req", master_req_o, 1'b1);
    master_gnt_i = 1'b1;
    tick();
    master_gnt_i = 1'b0;
    chk("dm_wait_busy", sbbusy_o, 1'b1);
    dmactive_i = 1'b0;
    tick();
    dmactive_i = 1'b1;
    chk("dm_idle", {sbbusy_o, master_req_o}, 2'b00);
    master_r_valid_i = 1'b1; master_r_rdata_i = 32'hFFFF;
    tick();
    master_r_valid_i = 1'b0;
    chk("dm_late_drop", {sbdata_valid_o, sberror_valid_o, sbbusy_o}, 3'b000);
    chk("dm_data_kept", sbdata_o, 128'h22222222_11111111);

    // grant never arrives
    trig_addr(3'd2, 32'h9000);
    sbreadonaddr_i = 1'b0;
`ifdef DM_SBA_TIMEOUT_EN
    cyc = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (sberror_valid_o) begin
        cyc = i;
        break;
      end
    end
    chk("tmo_cycles", cyc, 16);
    chk("tmo_code", sberror_o, 3'd1);
    chk("tmo_busy", sbbusy_o, 1'b0);
    tick();
`else
    errs = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (sberror_valid_o) errs++;
    end
    chk("notmo_errs", errs, 0);
    chk("notmo_req", master_req_o, 1'b1);
    dmactive_i = 1'b0;
    tick();
    dmactive_i = 1'b1;
`endif

    // asynchronous reset mid-request
    trig_addr(3'd2, 32'hA000);
    sbreadonaddr_i = 1'b0;
    chk("arst_pre_req", master_req_o, 1'b1);
    #2 rst_i = 1'b1;
    #1;
    chk("arst_req", master_req_o, 1'b0);
    chk("arst_busy", sbbusy_o, 1'b0);
    tick();
    rst_i = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
